param_register_file: RTL and testbench

PARAM_REGISTER_FILE -- requirements
Module: param_register_file

---
 rtl/param_register_file_if.sv | 29 ++
 rtl/param_register_file.sv | 53 +++++
 tb/tb_param_register_file.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/param_register_file_if.sv
// param_register_file_if: read, write-back, issue and scoreboard signals of the register file.
interface param_register_file_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4
);
   logic [ADDR_WIDTH-1:0]   src1;
   logic [ADDR_WIDTH-1:0]   src2;
   logic [DATA_WIDTH-1:0]   res1;
   logic [DATA_WIDTH-1:0]   res2;
   logic                    busy1;
   logic                    busy2;
   logic                    writeBackEn;
   logic [ADDR_WIDTH-1:0]   destWB;
   logic [DATA_WIDTH-1:0]   resultWB;
   logic [DATA_WIDTH/8-1:0] byteEnWB;
   logic                    issueEn;
   logic [ADDR_WIDTH-1:0]   issueDest;
   logic                    clearAll;
   logic                    anyBusy;
   logic                    wbErr;
   modport master (
      output src1, src2, writeBackEn, destWB, resultWB, byteEnWB, issueEn, issueDest, clearAll,
      input  res1, res2, busy1, busy2, anyBusy, wbErr
   );
   modport slave (
      input  src1, src2, writeBackEn, destWB, resultWB, byteEnWB, issueEn, issueDest, clearAll,
      output res1, res2, busy1, busy2, anyBusy, wbErr
   );
endinterface

// File: rtl/param_register_file.sv
// param_register_file: two-read register file with byte-enabled write-back, scoreboard and forwarding.
module param_register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter bit BYPASS     = 1'b1
) (
   input logic clk,
   input logic rst,
   param_register_file_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int NB    = DATA_WIDTH / 8;
   logic [DATA_WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0]      sb;
   logic [DEPTH-1:0]      sb_next;
   logic                  err;
   logic [DATA_WIDTH-1:0] mask;
   logic [DATA_WIDTH-1:0] merged;
   logic                  fwd1;
   logic                  fwd2;
   always_comb begin
      mask = '0;
      for (int k = 0; k < NB; k++) mask[8*k +: 8] = {8{bus.byteEnWB[k]}};
   end
   assign merged = (bus.resultWB & mask) | (regs[bus.destWB] & ~mask);
   // later assignments win: clearAll over issue over write-back
   always_comb begin
      sb_next = sb;
      if (bus.writeBackEn) sb_next[bus.destWB] = 1'b0;
      if (bus.issueEn) sb_next[bus.issueDest] = 1'b1;
      if (bus.clearAll) sb_next = '0;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= DATA_WIDTH'(i);
         sb  <= '0;
         err <= 1'b0;
      end else begin
         if (bus.writeBackEn) regs[bus.destWB] <= merged;
         sb  <= sb_next;
         err <= err | (bus.writeBackEn & ~sb[bus.destWB]);
      end
   end
   // forwarding is suppressed while reset holds so reads show reset contents
   assign fwd1 = BYPASS && rst && bus.writeBackEn && (bus.src1 == bus.destWB);
   assign fwd2 = BYPASS && rst && bus.writeBackEn && (bus.src2 == bus.destWB);
   assign bus.res1    = fwd1 ? merged : regs[bus.src1];
   assign bus.res2    = fwd2 ? merged : regs[bus.src2];
   assign bus.busy1   = sb[bus.src1] & ~(fwd1 & ~(bus.issueEn && bus.issueDest == bus.src1));
   assign bus.busy2   = sb[bus.src2] & ~(fwd2 & ~(bus.issueEn && bus.issueDest == bus.src2));
   assign bus.anyBusy = |sb;
   assign bus.wbErr   = err;
endmodule

// File: tb/tb_param_register_file.sv
// tb_param_register_file: directed checks of a default instance and a 64-bit/32-entry no-bypass instance.
module tb_param_register_file;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int errors = 0;
   int checks = 0;
   param_register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) a ();
   param_register_file_if #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) b ();
   param_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYPASS(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(a));
   param_register_file #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .BYPASS(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(b));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic idle_a();
      a.writeBackEn = 0; a.issueEn = 0; a.clearAll = 0; a.byteEnWB = '0; a.resultWB = '0;
   endtask
   initial begin
      idle_a();
      a.src1 = 1; a.src2 = 2; a.destWB = 0; a.issueDest = 0;
      b.src1 = 31; b.src2 = 0; b.writeBackEn = 0; b.destWB = 0; b.resultWB = '0;
      b.byteEnWB = '0; b.issueEn = 0; b.issueDest = 0; b.clearAll = 0;
      // strobes during reset must be ignored
      a.writeBackEn = 1; a.destWB = 1; a.resultWB = 32'hFF; a.byteEnWB = 4'hF;
      a.issueEn = 1; a.issueDest = 1;
      #32;
      chk("rst_res1", a.res1, 1);
      chk("rst_res2", a.res2, 2);
      chk("rst_busy1", a.busy1, 0);
      chk("rst_busy2", a.busy2, 0);
      chk("rst_any", a.anyBusy, 0);
      chk("rst_err", a.wbErr, 0);
      chk("b_rst_res31", b.res1, 31);
      idle_a();
      #5 rst = 1;
      @(negedge clk);
      chk("after_rst_res1", a.res1, 1);
      chk("after_rst_any", a.anyBusy, 0);
      // issue then write-back to index 1
      a.issueEn = 1; a.issueDest = 1;
      b.issueEn = 1; b.issueDest = 31;
      @(negedge clk);
      a.issueEn = 0; b.issueEn = 0;
      #1;
      chk("iss_busy1", a.busy1, 1);
      chk("iss_any", a.anyBusy, 1);
      chk("iss_res1", a.res1, 1);
      a.writeBackEn = 1; a.destWB = 1; a.resultWB = 32'h2; a.byteEnWB = 4'hF;
      b.writeBackEn = 1; b.destWB = 31; b.resultWB = 64'h0123456789ABCDEF; b.byteEnWB = 8'hFF;
      #1;
      chk("byp_res1", a.res1, 2);
      chk("byp_busy1", a.busy1, 0);
      chk("byp_any_reg", a.anyBusy, 1);
      chk("b_nobyp_res1", b.res1, 31);
      chk("b_nobyp_busy1", b.busy1, 1);
      @(negedge clk);
      idle_a(); b.writeBackEn = 0;
      #1;
      chk("wb_res1", a.res1, 2);
      chk("wb_any", a.anyBusy, 0);
      chk("wb_err", a.wbErr, 0);
      chk("b_wb_res1", b.res1, 64'h0123456789ABCDEF);
      chk("b_wb_busy1", b.busy1, 0);
      chk("b_wb_err", b.wbErr, 0);
      // byte enables on index 3
      a.src1 = 3; a.issueEn = 1; a.issueDest = 3;
      @(negedge clk);
      a.issueEn = 0;
      a.writeBackEn = 1; a.destWB = 3; a.resultWB = 32'hAABBCCDD; a.byteEnWB = 4'b0101;
      #1;
      chk("be_byp", a.res1, 32'h00BB00DD);
      @(negedge clk);
      idle_a(); a.issueEn = 1; a.issueDest = 3;
      #1;
      chk("be_res1", a.res1, 32'h00BB00DD);
      @(negedge clk);
      idle_a();
      a.writeBackEn = 1; a.destWB = 3; a.resultWB = 32'h11223344; a.byteEnWB = 4'b0000;
      #1;
      chk("be0_byp", a.res1, 32'h00BB00DD);
      chk("be0_busy1", a.busy1, 0);
      @(negedge clk);
      idle_a();
      #1;
      chk("be0_res1", a.res1, 32'h00BB00DD);
      chk("be0_busy_clr", a.busy1, 0);
      chk("be0_any", a.anyBusy, 0);
      chk("be0_err", a.wbErr, 0);
      // issue and write-back colliding on index 2
      a.src1 = 2; a.src2 = 2; a.issueEn = 1; a.issueDest = 2;
      @(negedge clk);
      a.writeBackEn = 1; a.destWB = 2; a.resultWB = 32'h55; a.byteEnWB = 4'hF;
      #1;
      chk("col_byp_res2", a.res2, 32'h55);
      chk("col_busy2", a.busy2, 1);
      @(negedge clk);
      idle_a();
      #1;
      chk("col_res2", a.res2, 32'h55);
      chk("col_same_port", a.res1, 32'h55);
      chk("col_busy_kept", a.busy2, 1);
      chk("col_any", a.anyBusy, 1);
      chk("col_err", a.wbErr, 0);
      // flush beats a simultaneous issue
      a.clearAll = 1; a.issueEn = 1; a.issueDest = 4;
      @(negedge clk);
      idle_a(); a.src1 = 4;
      #1;
      chk("flush_any", a.anyBusy, 0);
      chk("flush_busy1", a.busy1, 0);
      chk("flush_busy2", a.busy2, 0);
      // write-back to an idle index raises the sticky error
      a.writeBackEn = 1; a.destWB = 5; a.resultWB = 32'h77; a.byteEnWB = 4'hF;
      #1;
      chk("err_pre", a.wbErr, 0);
      @(negedge clk);
      idle_a(); a.src1 = 5; a.src2 = 15;
      #1;
      chk("err_set", a.wbErr, 1);
      chk("err_res1", a.res1, 32'h77);
      chk("top_index", a.res2, 15);
      a.clearAll = 1;
      @(negedge clk);
      a.clearAll = 0;
      #1;
      chk("err_after_flush", a.wbErr, 1);
      // reset mid-operation discards the pending write and issue
      a.writeBackEn = 1; a.destWB = 15; a.resultWB = 32'hDEAD; a.byteEnWB = 4'hF;
      a.issueEn = 1; a.issueDest = 6;
      #1 rst = 0;
      #1;
      chk("mid_err", a.wbErr, 0);
      chk("mid_res1", a.res1, 5);
      chk("mid_res2", a.res2, 15);
      chk("mid_any", a.anyBusy, 0);
      chk("b_mid_res1", b.res1, 31);
      @(negedge clk);
      chk("mid_hold_res2", a.res2, 15);
      chk("mid_hold_any", a.anyBusy, 0);
      a.issueEn = 0; a.resultWB = 32'hA5;
      rst = 1;
      #1;
      chk("rel_byp_res2", a.res2, 32'hA5);
      @(negedge clk);
      idle_a();
      #1;
      chk("rel_res2", a.res2, 32'hA5);
      chk("rel_err", a.wbErr, 1);
      chk("rel_any", a.anyBusy, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
